// File: rtl/bus_burst_sram_slave_if.sv
// Shared burst bus as seen by one responder: initiator-driven busIn_* and
// responder-driven busOut_* signals, grouped with master/slave views.
interface bus_burst_sram_slave_if;
    logic        busIn_begin_transaction;
    logic [31:0] busIn_address_data;
    logic [7:0]  busIn_burst_size;
    logic        busIn_read_n_write;
    logic        busIn_data_valid;
    logic        busIn_end_transaction;
    logic        busIn_busy;
    logic [31:0] busOut_address_data;
    logic        busOut_data_valid;
    logic        busOut_end_transaction;
    logic        busOut_busy;
    logic        busOut_error;

    modport slave (
        input  busIn_begin_transaction, busIn_address_data, busIn_burst_size,
               busIn_read_n_write, busIn_data_valid, busIn_end_transaction, busIn_busy,
        output busOut_address_data, busOut_data_valid, busOut_end_transaction,
               busOut_busy, busOut_error
    );

    modport master (
        output busIn_begin_transaction, busIn_address_data, busIn_burst_size,
               busIn_read_n_write, busIn_data_valid, busIn_end_transaction, busIn_busy,
        input  busOut_address_data, busOut_data_valid, busOut_end_transaction,
               busOut_busy, busOut_error
    );
endinterface

// File: rtl/bus_burst_sram_slave.sv
// SRAM window responder for the shared burst bus: single/burst reads and writes
// into an on-chip word array, with error reporting for out-of-window bursts.
module bus_burst_sram_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          NR_OF_WORDS  = 512
) (
    input  logic                    clock,
    input  logic                    reset,
    bus_burst_sram_slave_if.slave   bus
);
    localparam int AW = $clog2(NR_OF_WORDS);
    localparam logic [AW-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {IDLE, READ, READ_END, WRITE, WRITE_ERR, ERR_END} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [8:0]    fetch_left_q, fetch_left_d;
    logic [8:0]    left_q, left_d;
    logic          valid_q, valid_d;
    logic          excess_q, excess_d;
    logic          err_phase_q, err_phase_d;

    logic [31:0]   mem [NR_OF_WORDS];
    logic [31:0]   rdata_q;
    logic          mem_we;
    logic          mem_re;

    logic          in_window;
    logic [AW-1:0] start_word;
    logic [8:0]    burst_len;
    logic          overrun;
    logic          accept;
    logic          excess_pulse;

    assign in_window  = (bus.busIn_address_data[31:AW+2] == BASE_ADDRESS[31:AW+2]);
    assign start_word = bus.busIn_address_data[AW+1:2];
    assign burst_len  = {1'b0, bus.busIn_burst_size} + 9'd1;
    assign overrun    = (int'(start_word) + int'(burst_len)) > NR_OF_WORDS;
    assign accept     = valid_q && !bus.busIn_busy;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        fetch_left_d = fetch_left_q;
        left_d       = left_q;
        valid_d      = valid_q;
        excess_d     = excess_q;
        err_phase_d  = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        excess_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d  = 1'b0;
                excess_d = 1'b0;
                if (bus.busIn_begin_transaction && in_window) begin
                    addr_d       = start_word;
                    left_d       = burst_len;
                    fetch_left_d = burst_len;
                    if (overrun) begin
                        state_d     = bus.busIn_read_n_write ? ERR_END : WRITE_ERR;
                        err_phase_d = 1'b1;
                    end else begin
                        state_d = bus.busIn_read_n_write ? READ : WRITE;
                    end
                end
            end
            READ: begin
                if (bus.busIn_end_transaction) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else begin
                    // The output register only reloads once the presented word
                    // is gone, so a stalled word stays put and none is skipped.
                    if (!valid_q || accept) begin
                        if (fetch_left_q != 9'd0) begin
                            mem_re       = 1'b1;
                            addr_d       = addr_q + ADDR_ONE;
                            fetch_left_d = fetch_left_q - 9'd1;
                            valid_d      = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                    if (accept) begin
                        left_d = left_q - 9'd1;
                        if (left_q == 9'd1) begin
                            state_d = READ_END;
                        end
                    end
                end
            end
            READ_END: state_d = IDLE;
            WRITE: begin
                if (bus.busIn_data_valid) begin
                    if (left_q != 9'd0) begin
                        mem_we = 1'b1;
                        addr_d = addr_q + ADDR_ONE;
                        left_d = left_q - 9'd1;
                    end else if (!excess_q) begin
                        excess_pulse = 1'b1;
                        excess_d     = 1'b1;
                    end
                end
                if (bus.busIn_end_transaction) begin
                    state_d = IDLE;
                end
            end
            WRITE_ERR: begin
                if (bus.busIn_end_transaction) begin
                    state_d = IDLE;
                end
            end
            ERR_END: begin
                if (!err_phase_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            fetch_left_q <= '0;
            left_q       <= '0;
            valid_q      <= 1'b0;
            excess_q     <= 1'b0;
            err_phase_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            fetch_left_q <= fetch_left_d;
            left_q       <= left_d;
            valid_q      <= valid_d;
            excess_q     <= excess_d;
            err_phase_q  <= err_phase_d;
        end
    end

    // Array contents survive reset; the read register is masked by valid_q.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q] <= bus.busIn_address_data;
        end
        if (mem_re) begin
            rdata_q <= mem[addr_q];
        end
    end

    assign bus.busOut_data_valid      = valid_q;
    assign bus.busOut_address_data    = valid_q ? rdata_q : 32'd0;
    assign bus.busOut_end_transaction = (state_q == READ_END) || ((state_q == ERR_END) && !err_phase_q);
    assign bus.busOut_error           = err_phase_q || excess_pulse;
    assign bus.busOut_busy            = 1'b0;
endmodule

// File: tb/tb_bus_burst_sram_slave.sv
// Randomized scoreboard bench for bus_burst_sram_slave: a word-array model
// predicts read data, acceptance cycles, end markers and error pulses.
module tb_bus_burst_sram_slave;
    localparam logic [31:0] BASE = 32'h5000_0000;
    localparam int NW = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [31:0] ref_mem [NW];
    logic [31:0] exp_data [$];
    int          exp_dcyc [$];
    int          exp_end [$];
    int          exp_err [$];

    bus_burst_sram_slave_if bus();

    bus_burst_sram_slave dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_pop(input string name, inout int q[$]);
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected pulse at cycle %0d", name, cyc);
        end else begin
            chk(name, cyc, q.pop_front());
        end
    endtask

    // Monitor: compares every output event against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.busOut_data_valid) chk("idle_data_zero", bus.busOut_address_data, 32'd0);
            chk("busy_out", {31'd0, bus.busOut_busy}, 32'd0);
            if (bus.busOut_data_valid && !bus.busIn_busy) begin
                if (exp_data.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got %h at cycle %0d", bus.busOut_address_data, cyc);
                end else begin
                    chk("read_data", bus.busOut_address_data, exp_data.pop_front());
                    chk("read_cycle", cyc, exp_dcyc.pop_front());
                end
            end
            if (bus.busOut_end_transaction) chk_pop("end_cycle", exp_end);
            if (bus.busOut_error) chk_pop("error_cycle", exp_err);
        end
    end

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd2048);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        bus.busIn_begin_transaction = 1'b0;
        bus.busIn_address_data      = 32'd0;
        bus.busIn_burst_size        = 8'd0;
        bus.busIn_read_n_write      = 1'b0;
        bus.busIn_data_valid        = 1'b0;
        bus.busIn_end_transaction   = 1'b0;
        bus.busIn_busy              = 1'b0;
    endtask

    task automatic begin_txn(input logic [31:0] addr, input int bsize, input bit rnw);
        step();
        bus.busIn_begin_transaction = 1'b1;
        bus.busIn_address_data      = addr;
        bus.busIn_burst_size        = bsize[7:0];
        bus.busIn_read_n_write      = rnw;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_data"},  bus.busOut_address_data, 32'd0);
        chk({name, "_valid"}, {31'd0, bus.busOut_data_valid}, 32'd0);
        chk({name, "_end"},   {31'd0, bus.busOut_end_transaction}, 32'd0);
        chk({name, "_error"}, {31'd0, bus.busOut_error}, 32'd0);
    endtask

    // busy_mode: -1 = use fixed_busy bits, otherwise percent chance of busy.
    task automatic do_read(input logic [31:0] addr, input int bsize, input int busy_mode,
                           input logic [15:0] fixed_busy, input bit stray);
        int len = bsize + 1;
        int t0;
        int word;
        int zeros = 0;
        bit pat[$];
        begin_txn(addr, bsize, 1'b1);
        t0 = cyc;
        if (!in_win(addr)) return;
        word = int'((addr - BASE) >> 2);
        if (word + len > NW) begin
            exp_err.push_back(t0 + 1);
            exp_end.push_back(t0 + 2);
            step();
            step();
            return;
        end
        while (zeros < len) begin
            bit b;
            if (busy_mode < 0) b = (pat.size() < 16) ? fixed_busy[pat.size()] : 1'b0;
            else b = ($urandom_range(0, 99) < busy_mode);
            if (!b) begin
                exp_data.push_back(ref_mem[word + zeros]);
                exp_dcyc.push_back(t0 + 2 + pat.size());
                zeros++;
            end
            pat.push_back(b);
        end
        exp_end.push_back(t0 + 2 + pat.size());
        step();
        foreach (pat[i]) begin
            step();
            bus.busIn_busy = pat[i];
            if (stray && $urandom_range(0, 3) == 0) begin
                bus.busIn_begin_transaction = 1'b1;
                bus.busIn_address_data      = BASE + ($urandom_range(0, 511) << 2);
                bus.busIn_burst_size        = 8'($urandom_range(0, 7));
                bus.busIn_read_n_write      = 1'($urandom_range(0, 1));
            end
        end
        step();
    endtask

    task automatic do_write(input logic [31:0] addr, input int bsize, input int nwords,
                            input bit gaps, input bit use_fixed, input logic [31:0] d0);
        int len = bsize + 1;
        int t0;
        int word;
        bit win;
        bit ovr;
        begin_txn(addr, bsize, 1'b0);
        t0 = cyc;
        win = in_win(addr);
        word = int'((addr - BASE) >> 2);
        ovr = win && (word + len > NW);
        if (ovr) exp_err.push_back(t0 + 1);
        for (int i = 0; i < nwords; i++) begin
            logic [31:0] d;
            d = use_fixed ? d0 + 32'(i) : $urandom;
            if (gaps && $urandom_range(0, 2) == 0) step();
            step();
            bus.busIn_data_valid   = 1'b1;
            bus.busIn_address_data = d;
            if (win && !ovr) begin
                if (i < len) ref_mem[word + i] = d;
                else if (i == len) exp_err.push_back(cyc);
            end
        end
        step();
        bus.busIn_end_transaction = 1'b1;
    endtask

    task automatic do_read_abort(input logic [31:0] addr);
        int word = int'((addr - BASE) >> 2);
        int t0;
        begin_txn(addr, 5, 1'b1);
        t0 = cyc;
        exp_data.push_back(ref_mem[word]);
        exp_dcyc.push_back(t0 + 2);
        step();
        step();
        step();
        bus.busIn_busy            = 1'b1;
        bus.busIn_end_transaction = 1'b1;
        step();
        @(negedge clk);
        chk_outputs_zero("after_abort");
    endtask

    task automatic do_read_reset(input logic [31:0] addr);
        int word = int'((addr - BASE) >> 2);
        int t0;
        begin_txn(addr, 7, 1'b1);
        t0 = cyc;
        exp_data.push_back(ref_mem[word]);
        exp_dcyc.push_back(t0 + 2);
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.busIn_begin_transaction = 1'b0;
        bus.busIn_address_data      = 32'd0;
        bus.busIn_burst_size        = 8'd0;
        bus.busIn_read_n_write      = 1'b0;
        bus.busIn_data_valid        = 1'b0;
        bus.busIn_end_transaction   = 1'b0;
        bus.busIn_busy              = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset_state");
        rst = 1'b0;

        // Fill the whole window; the second burst ends exactly on the last word.
        do_write(BASE, 255, 256, 1'b0, 1'b0, 32'd0);
        do_write(BASE + 32'h400, 255, 256, 1'b0, 1'b0, 32'd0);

        do_write(BASE + 32'h10, 3, 4, 1'b0, 1'b1, 32'hA0);
        do_read(BASE + 32'h10, 3, 0, 16'h0, 1'b0);
        do_read(BASE + 32'h10, 3, -1, 16'h0006, 1'b0);
        do_read(BASE + 32'h7FC, 1, 0, 16'h0, 1'b0);
        do_read(BASE + 32'h7FC, 0, 0, 16'h0, 1'b0);
        do_read(32'h4000_0000, 3, 0, 16'h0, 1'b0);
        step();
        step();
        do_write(BASE + 32'h50, 1, 3, 1'b0, 1'b0, 32'd0);
        do_read(BASE + 32'h50, 2, 0, 16'h0, 1'b0);
        do_write(BASE + 32'h7F0, 7, 3, 1'b0, 1'b0, 32'd0);
        do_read(BASE + 32'h7F0, 3, 0, 16'h0, 1'b0);
        do_read_abort(BASE + 32'h20);
        do_read(BASE + 32'h20, 4, 0, 16'h0, 1'b0);
        do_read_reset(BASE + 32'h100);
        do_read(BASE + 32'h100, 7, 0, 16'h0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int r = int'($urandom_range(0, 9));
            int bsize = int'($urandom_range(0, 15));
            int nw;
            logic [31:0] a;
            if (r == 0) a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'h800 + ($urandom_range(0, 255) << 2);
            else if (r == 1) a = BASE + ($urandom_range(500, 511) << 2);
            else a = BASE + ($urandom_range(0, 511) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                nw = bsize + 1 + int'($urandom_range(0, 3)) - 1;
                do_write(a, bsize, nw, 1'b1, 1'b0, 32'd0);
            end else begin
                do_read(a, bsize, 30, 16'h0, 1'b1);
            end
        end

        step();
        step();
        step();
        chk("pending_reads", exp_data.size(), 32'd0);
        chk("pending_ends", exp_end.size(), 32'd0);
        chk("pending_errors", exp_err.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
